lcd_spi_tx: RTL and testbench

Byte-level SPI transmitter for the 0.96" ST7735-class PMOD LCD, sitting directly downstream of the command/parameter sequencers (reset, FRMCTR1, waveform pixel writer). It accepts {DC, byte} entries over a valid/ready handshake and buffers them in a small FIFO. It serialises each entry MSB-first onto SCL/MOSI, with CS framing and DC steering. Sequencers only produce bytes and no longer toggle SPI pins themselves.

---
 rtl/lcd_spi_tx.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_spi_tx.sv | 547 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: byte-level SPI transmitter for an ST7735-class LCD.
// Accepts {dc, byte} entries into a small FIFO, then shifts each byte out
// MSB-first on SCL/MOSI, framed by CS, with DC held steady while CS is low.
// Optional feature macro: LCD_SPI_CS_BURST_EN. When it is defined, consecutive
// entries that have the same dc share a single CS frame.
module lcd_spi_tx #(
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       IN_VALID,
  input  logic       IN_DC,
  input  logic [7:0] IN_DATA,
  output logic       IN_READY,
  output logic       BUSY,
  output logic       SCL,
  output logic       MOSI,
  output logic       DC,
  output logic       CS
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ENT_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_t;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop_c;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_nxt;
  logic             div_done;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             scl_nxt;
  logic             mosi_nxt;
  logic             dc_nxt;
  logic             cs_nxt;

  assign IN_READY   = (count < CNT_W'(FIFO_DEPTH));
  assign push       = IN_VALID && IN_READY;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign BUSY       = !fifo_empty || (state != S_IDLE);
  assign div_done   = (div_cnt == DIV_W'(CLK_DIV - 1));

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {IN_DC, IN_DATA};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth wraps naturally
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser state and pin registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_idx <= 3'd7;
      shift   <= '0;
      SCL     <= 1'b1;
      MOSI    <= 1'b1;
      DC      <= 1'b1;
      CS      <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      SCL     <= scl_nxt;
      MOSI    <= mosi_nxt;
      DC      <= dc_nxt;
      CS      <= cs_nxt;
    end
  end

  // Next-state, pop request and next pin values
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    scl_nxt     = SCL;
    mosi_nxt    = MOSI;
    dc_nxt      = DC;
    cs_nxt      = CS;
    pop_c       = 1'b0;
    case (state)
      S_IDLE: begin
        scl_nxt     = 1'b1;
        cs_nxt      = 1'b1;
        div_cnt_nxt = '0;
        if (!fifo_empty) begin
          pop_c       = 1'b1;
          shift_nxt   = head[7:0];
          dc_nxt      = head[8];
          mosi_nxt    = head[7];
          cs_nxt      = 1'b0;
          bit_idx_nxt = 3'd7;
          state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_done) begin
          div_cnt_nxt = '0;
          scl_nxt     = 1'b0;
          state_nxt   = S_LOW;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      S_LOW: begin
        if (div_done) begin
          div_cnt_nxt = '0;
          scl_nxt     = 1'b1;
          state_nxt   = S_HIGH;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_done) begin
          div_cnt_nxt = '0;
          if (bit_idx != 3'd0) begin
            // next bit launches together with the SCL fall
            bit_idx_nxt = bit_idx - 3'd1;
            mosi_nxt    = shift[bit_idx_nxt];
            scl_nxt     = 1'b0;
            state_nxt   = S_LOW;
          end
`ifdef LCD_SPI_CS_BURST_EN
          else if (!fifo_empty && (head[8] == DC)) begin
            // same dc queued: chain the next byte without releasing CS
            pop_c       = 1'b1;
            shift_nxt   = head[7:0];
            mosi_nxt    = head[7];
            bit_idx_nxt = 3'd7;
            scl_nxt     = 1'b0;
            state_nxt   = S_LOW;
          end
`endif
          else begin
            cs_nxt    = 1'b1;
            state_nxt = S_GAP;
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (div_done) begin
          div_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Testbench for lcd_spi_tx: two instances (CLK_DIV=1 and CLK_DIV=2), a pin-level
// SPI decoder and a slot-timing reference model built from accept cycles.
`timescale 1ns/1ps
module tb_lcd_spi_tx;

  localparam int D1 = 1;
  localparam int D2 = 2;
`ifdef LCD_SPI_CS_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         acc;
  } acc_t;

  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         lr;
    bit         nf;
  } byte_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_dc;
  logic [7:0] in_data;
  bit         sel = 1'b0;

  logic v1, v2;
  logic rdy1, busy1, scl1, mosi1, dc1, cs1;
  logic rdy2, busy2, scl2, mosi2, dc2, cs2;
  logic rdy_m, busy_m, scl_m, mosi_m, dc_m, cs_m;

  int cyc = 0;
  int compared = 0;
  int failed = 0;

  acc_t  acc_q[$];
  byte_t got_q[$];
  byte_t exp_q[$];

  int         bits = 0;
  logic [7:0] sh = 8'h00;
  bit         nf_pend = 1'b0;
  int         last_rise = 0;
  int         last_fall = 0;
  int         scl_falls = 0;
  logic       prev_cs = 1'b1;
  logic       prev_scl = 1'b1;
  logic       prev_dc = 1'b1;
  logic       prev_mosi = 1'b1;

  assign v1 = in_valid && !sel;
  assign v2 = in_valid && sel;

  assign rdy_m  = sel ? rdy2  : rdy1;
  assign busy_m = sel ? busy2 : busy1;
  assign scl_m  = sel ? scl2  : scl1;
  assign mosi_m = sel ? mosi2 : mosi1;
  assign dc_m   = sel ? dc2   : dc1;
  assign cs_m   = sel ? cs2   : cs1;

  lcd_spi_tx #(.CLK_DIV(D1), .FIFO_DEPTH(4)) dut1 (
    .CLK(clk), .RSTN(rst_n), .IN_VALID(v1), .IN_DC(in_dc), .IN_DATA(in_data),
    .IN_READY(rdy1), .BUSY(busy1), .SCL(scl1), .MOSI(mosi1), .DC(dc1), .CS(cs1)
  );

  lcd_spi_tx #(.CLK_DIV(D2), .FIFO_DEPTH(4)) dut2 (
    .CLK(clk), .RSTN(rst_n), .IN_VALID(v2), .IN_DC(in_dc), .IN_DATA(in_data),
    .IN_READY(rdy2), .BUSY(busy2), .SCL(scl2), .MOSI(mosi2), .DC(dc2), .CS(cs2)
  );

  always #5 clk = ~clk;

  // edge counter: after rising edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // SPI decoder and pin-protocol watcher on the selected instance
  always @(negedge clk) begin : mon
    int d;
    d = sel ? D2 : D1;
    if (!rst_n) begin
      bits    = 0;
      nf_pend = 1'b0;
    end else begin
      if (prev_cs && !cs_m) begin
        nf_pend   = 1'b1;
        bits      = 0;
        last_fall = cyc;
      end
      if (!prev_cs && !cs_m) begin
        compared++;
        if (dc_m !== prev_dc) begin
          failed++;
          $display("FAIL dc_stable: cyc %0d dc=%b, required %b while CS low", cyc, dc_m, prev_dc);
        end
        if (!(prev_scl && !scl_m)) begin
          compared++;
          if (mosi_m !== prev_mosi) begin
            failed++;
            $display("FAIL mosi_timing: cyc %0d mosi=%b, required %b (no SCL fall)", cyc, mosi_m, prev_mosi);
          end
        end
      end
      if (prev_scl && !scl_m) scl_falls++;
      if (!cs_m && !prev_scl && scl_m) begin
        sh = {sh[6:0], mosi_m};
        bits++;
        if (bits == 8) begin
          got_q.push_back('{dc_m, sh, cyc, nf_pend});
          nf_pend   = 1'b0;
          bits      = 0;
          last_rise = cyc;
        end
      end
      if (!prev_cs && cs_m) begin
        compared++;
        if ((cyc - last_rise) != d || bits != 0) begin
          failed++;
          $display("FAIL cs_rise: cyc %0d delay=%0d bits=%0d, required delay=%0d bits=0",
                   cyc, cyc - last_rise, bits, d);
        end
      end
    end
    prev_cs   = cs_m;
    prev_scl  = scl_m;
    prev_dc   = dc_m;
    prev_mosi = mosi_m;
  end

  task automatic set_idle();
    in_valid = 1'b0;
    in_dc    = 1'b0;
    in_data  = 8'h00;
  endtask

  // Offer one entry (called at a negedge); returns the edge it is accepted on.
  task automatic push_entry(input logic dc, input logic [7:0] d, output int acc);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_dc    = dc;
    in_data  = d;
    while (rdy_m !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      compared++;
      failed++;
      $display("FAIL push_timeout: entry %h not accepted, required acceptance", d);
      acc = -1;
    end else begin
      acc = cyc + 1;
      acc_q.push_back('{dc, d, acc});
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int n, output bit ok);
    int w;
    w = 0;
    while ((got_q.size() < n || busy_m !== 1'b0) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    ok = (w < 5000);
  endtask

  // Reference: byte order from the accept list, 8th-SCL-rise cycle from slot rules
  task automatic build_model();
    int   last_l;
    logic last_dc;
    bit   have;
    int   d;
    int   st;
    d       = sel ? D2 : D1;
    have    = 1'b0;
    last_l  = 0;
    last_dc = 1'b0;
    exp_q.delete();
    foreach (acc_q[i]) begin
      byte_t e;
      e.dc   = acc_q[i].dc;
      e.data = acc_q[i].data;
      if (have && BURST && acc_q[i].dc == last_dc && acc_q[i].acc < last_l + d) begin
        e.lr = last_l + 16 * d;
        e.nf = 1'b0;
      end else begin
        st = acc_q[i].acc;
        if (have && (last_l + 2 * d) > st) st = last_l + 2 * d;
        e.lr = st + 1 + 16 * d;
        e.nf = 1'b1;
      end
      exp_q.push_back(e);
      last_l  = e.lr;
      last_dc = e.dc;
      have    = 1'b1;
    end
  endtask

  task automatic clear_queues();
    acc_q.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    repeat (3) @(negedge clk);
    compared++;
    if ({cs1, scl1, dc1, mosi1, rdy1, busy1} !== 6'b111110) begin
      failed++;
      $display("FAIL reset_during: pins=%b, required 111110", {cs1, scl1, dc1, mosi1, rdy1, busy1});
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      compared++;
      if ({cs1, scl1, dc1, mosi1, rdy1, busy1} !== 6'b111110) begin
        failed++;
        $display("FAIL reset_idle1: pins=%b, required 111110", {cs1, scl1, dc1, mosi1, rdy1, busy1});
      end
      compared++;
      if ({cs2, scl2, dc2, mosi2, rdy2, busy2} !== 6'b111110) begin
        failed++;
        $display("FAIL reset_idle2: pins=%b, required 111110", {cs2, scl2, dc2, mosi2, rdy2, busy2});
      end
    end
  endtask

  task automatic test_single();
    int a;
    bit ok;
    sel = 1'b0;
    clear_queues();
    @(negedge clk);
    push_entry(1'b0, 8'hB1, a);
    set_idle();
    compared++;
    if (busy_m !== 1'b1) begin
      failed++;
      $display("FAIL single_busy: busy=%b, required 1", busy_m);
    end
    wait_done(1, ok);
    compared++;
    if (!ok) begin
      failed++;
      $display("FAIL single_done: timeout, required 1 byte");
    end
    compared++;
    if (last_fall != a + 1) begin
      failed++;
      $display("FAIL single_latency: cs fall %0d, required %0d", last_fall, a + 1);
    end
    build_model();
    compared++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL single_count: %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if ({got_q[i].dc, got_q[i].data} !== {exp_q[i].dc, exp_q[i].data}) begin
        failed++;
        $display("FAIL single_byte%0d: %b/%h, required %b/%h", i, got_q[i].dc, got_q[i].data, exp_q[i].dc, exp_q[i].data);
      end
      compared++;
      if (got_q[i].lr != exp_q[i].lr) begin
        failed++;
        $display("FAIL single_time%0d: %0d, required %0d", i, got_q[i].lr, exp_q[i].lr);
      end
    end
  endtask

  task automatic test_frmctr1();
    int   a;
    bit   ok;
    logic [8:0] seq [4];
    seq[0] = {1'b0, 8'hB1};
    seq[1] = {1'b1, 8'h05};
    seq[2] = {1'b1, 8'h3C};
    seq[3] = {1'b1, 8'h3C};
    sel = 1'b0;
    clear_queues();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_entry(seq[i][8], seq[i][7:0], a);
      compared++;
      if (rdy_m !== 1'b1) begin
        failed++;
        $display("FAIL frm_ready%0d: ready=%b, required 1", i, rdy_m);
      end
    end
    set_idle();
    wait_done(4, ok);
    compared++;
    if (!ok) begin
      failed++;
      $display("FAIL frm_done: timeout, required 4 bytes");
    end
    build_model();
    compared++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL frm_count: %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if ({got_q[i].dc, got_q[i].data} !== {exp_q[i].dc, exp_q[i].data}) begin
        failed++;
        $display("FAIL frm_byte%0d: %b/%h, required %b/%h", i, got_q[i].dc, got_q[i].data, exp_q[i].dc, exp_q[i].data);
      end
      compared++;
      if (got_q[i].lr != exp_q[i].lr || got_q[i].nf != exp_q[i].nf) begin
        failed++;
        $display("FAIL frm_slot%0d: t=%0d nf=%b, required t=%0d nf=%b", i, got_q[i].lr, got_q[i].nf, exp_q[i].lr, exp_q[i].nf);
      end
    end
    if (got_q.size() >= 2) begin
      compared++;
      if (got_q[1].lr - got_q[0].lr != 18 * D1 + 1) begin
        failed++;
        $display("FAIL frm_spacing: %0d, required %0d", got_q[1].lr - got_q[0].lr, 18 * D1 + 1);
      end
    end
  endtask

  task automatic test_full();
    int   a;
    int   acc5;
    bit   ok;
    logic [8:0] seq [6];
    seq[0] = {1'b0, 8'h2A};
    seq[1] = {1'b1, 8'h00};
    seq[2] = {1'b1, 8'h7F};
    seq[3] = {1'b0, 8'h2B};
    seq[4] = {1'b1, 8'h01};
    seq[5] = {1'b1, 8'h9F};
    sel = 1'b1;
    clear_queues();
    acc5 = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      push_entry(seq[i][8], seq[i][7:0], a);
      if (i == 4) begin
        acc5 = a;
        compared++;
        if (rdy_m !== 1'b0) begin
          failed++;
          $display("FAIL full_ready: ready=%b after 5th accept, required 0", rdy_m);
        end
      end
      if (i == 5) begin
        compared++;
        if (a <= acc5 + 1) begin
          failed++;
          $display("FAIL full_held: 6th accepted at %0d, required later than %0d", a, acc5 + 1);
        end
      end
    end
    set_idle();
    wait_done(6, ok);
    compared++;
    if (!ok) begin
      failed++;
      $display("FAIL full_done: timeout, required 6 bytes");
    end
    build_model();
    compared++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL full_count: %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      compared++;
      if ({got_q[i].dc, got_q[i].data} !== {exp_q[i].dc, exp_q[i].data}) begin
        failed++;
        $display("FAIL full_byte%0d: %b/%h, required %b/%h", i, got_q[i].dc, got_q[i].data, exp_q[i].dc, exp_q[i].data);
      end
      compared++;
      if (got_q[i].lr != exp_q[i].lr || got_q[i].nf != exp_q[i].nf) begin
        failed++;
        $display("FAIL full_slot%0d: t=%0d nf=%b, required t=%0d nf=%b", i, got_q[i].lr, got_q[i].nf, exp_q[i].lr, exp_q[i].nf);
      end
    end
  endtask

  task automatic test_burst();
    int a;
    bit ok;
    sel = 1'b0;
    clear_queues();
    @(negedge clk);
    push_entry(1'b1, 8'hAA, a);
    push_entry(1'b1, 8'h55, a);
    push_entry(1'b0, 8'h2C, a);
    set_idle();
    wait_done(3, ok);
    compared++;
    if (!ok) begin
      failed++;
      $display("FAIL burst_done: timeout, required 3 bytes");
    end
    build_model();
    compared++;
    if (got_q.size() != 3) begin
      failed++;
      $display("FAIL burst_count: %0d bytes, required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if ({got_q[i].dc, got_q[i].data} !== {exp_q[i].dc, exp_q[i].data}
            || got_q[i].lr != exp_q[i].lr || got_q[i].nf != exp_q[i].nf) begin
          failed++;
          $display("FAIL burst_byte%0d: %b/%h t=%0d nf=%b, required %b/%h t=%0d nf=%b", i,
                   got_q[i].dc, got_q[i].data, got_q[i].lr, got_q[i].nf,
                   exp_q[i].dc, exp_q[i].data, exp_q[i].lr, exp_q[i].nf);
        end
      end
      compared++;
      if (got_q[1].nf !== !BURST || got_q[2].nf !== 1'b1) begin
        failed++;
        $display("FAIL burst_frame: nf55=%b nf2C=%b, required %b 1", got_q[1].nf, got_q[2].nf, !BURST);
      end
      compared++;
      if (got_q[1].lr - got_q[0].lr != (BURST ? 16 * D1 : 18 * D1 + 1)) begin
        failed++;
        $display("FAIL burst_slot: %0d, required %0d", got_q[1].lr - got_q[0].lr, BURST ? 16 * D1 : 18 * D1 + 1);
      end
    end
  endtask

  task automatic test_random();
    int a;
    int gap;
    bit ok;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      clear_queues();
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        push_entry(($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1, 8'($urandom), a);
        set_idle();
        gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : int'($urandom_range(0, 2));
        repeat (gap) @(negedge clk);
      end
      wait_done(10, ok);
      compared++;
      if (!ok) begin
        failed++;
        $display("FAIL rand_done%0d: timeout, required 10 bytes", s);
      end
      build_model();
      compared++;
      if (got_q.size() != exp_q.size()) begin
        failed++;
        $display("FAIL rand_count%0d: %0d bytes, required %0d", s, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        compared++;
        if ({got_q[i].dc, got_q[i].data} !== {exp_q[i].dc, exp_q[i].data}
            || got_q[i].lr != exp_q[i].lr || got_q[i].nf != exp_q[i].nf) begin
          failed++;
          $display("FAIL rand%0d_byte%0d: %b/%h t=%0d nf=%b, required %b/%h t=%0d nf=%b", s, i,
                   got_q[i].dc, got_q[i].data, got_q[i].lr, got_q[i].nf,
                   exp_q[i].dc, exp_q[i].data, exp_q[i].lr, exp_q[i].nf);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int a;
    int w;
    int falls;
    int nbytes;
    sel = 1'b0;
    clear_queues();
    @(negedge clk);
    push_entry(1'b1, 8'h3C, a);
    push_entry(1'b1, 8'h11, a);
    push_entry(1'b1, 8'h22, a);
    set_idle();
    w = 0;
    while (bits != 3 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    compared++;
    if (w >= 200) begin
      failed++;
      $display("FAIL mid_reach: bits=%0d, required 3", bits);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({cs1, scl1, dc1, mosi1, rdy1, busy1} !== 6'b111110) begin
      failed++;
      $display("FAIL mid_async: pins=%b, required 111110", {cs1, scl1, dc1, mosi1, rdy1, busy1});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    falls  = scl_falls;
    nbytes = got_q.size();
    repeat (40) @(negedge clk);
    compared++;
    if (scl_falls != falls || got_q.size() != nbytes) begin
      failed++;
      $display("FAIL mid_quiet: scl falls +%0d bytes +%0d, required 0 0", scl_falls - falls, got_q.size() - nbytes);
    end
    compared++;
    if ({cs1, busy1} !== 2'b10) begin
      failed++;
      $display("FAIL mid_after: cs=%b busy=%b, required 1 0", cs1, busy1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_single();
    test_frmctr1();
    test_full();
    test_burst();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
